// File: rtl/mem_arbiter_if.sv
// Bundle of the IF / LS request ports and the mem_control read/write ports.
// The arbiter uses the slave view; the core/memory side uses the master view.
`ifndef MEM_ACCESS_BYTE
`define MEM_ACCESS_BYTE 2'b00
`endif
`ifndef MEM_ACCESS_HALFWORD
`define MEM_ACCESS_HALFWORD 2'b01
`endif
`ifndef MEM_ACCESS_WORD
`define MEM_ACCESS_WORD 2'b10
`endif

interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;

  logic        ls_req_i;
  logic        ls_we_i;
  logic [1:0]  ls_acc_i;
  logic        ls_sext_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        ls_wdone_o;
  logic        ls_err_o;

  logic        r_en_o;
  logic        sext_o;
  logic [1:0]  acc_r_o;
  logic [31:0] addr_r_o;
  logic [31:0] data_r_i;

  logic        wr_en_o;
  logic [1:0]  acc_w_o;
  logic [31:0] addr_w_o;
  logic [31:0] data_w_o;
  logic        wr_ready_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  ls_req_i, ls_we_i, ls_acc_i, ls_sext_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_wdone_o, ls_err_o,
    output r_en_o, sext_o, acc_r_o, addr_r_o,
    input  data_r_i,
    output wr_en_o, acc_w_o, addr_w_o, data_w_o,
    input  wr_ready_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output ls_req_i, ls_we_i, ls_acc_i, ls_sext_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_wdone_o, ls_err_o,
    input  r_en_o, sext_o, acc_r_o, addr_r_o,
    output data_r_i,
    input  wr_en_o, acc_w_o, addr_w_o, data_w_o,
    output wr_ready_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing mem_control between instruction fetch and load/store,
// one transaction in flight, with the two-cycle read-modify-write store sequence.
`ifndef MEM_ACCESS_BYTE
`define MEM_ACCESS_BYTE 2'b00
`endif
`ifndef MEM_ACCESS_HALFWORD
`define MEM_ACCESS_HALFWORD 2'b01
`endif
`ifndef MEM_ACCESS_WORD
`define MEM_ACCESS_WORD 2'b10
`endif

module mem_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WR_ISSUE, WR_PEND} state_e;
  typedef enum logic {SRC_IF, SRC_LS} src_e;

  localparam int unsigned     CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  state_e            state_q, state_d;
  src_e              last_grant_q, src_q, winner;

  logic              sext_q;
  logic [1:0]        acc_q;
  logic [31:0]       addr_q;
  logic [1:0]        wacc_q;
  logic [31:0]       waddr_q, wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       if_rdata_q, ls_rdata_q;
  logic              if_rvalid_q, ls_rvalid_q, ls_wdone_q, if_err_q, ls_err_q;

  logic              accept, win_ls, misaligned, rd_last;
  logic [1:0]        win_acc;
  logic [31:0]       win_addr;

  // Tie goes to whichever source was not granted last.
  always_comb begin
    win_ls     = bus.ls_req_i && (!bus.if_req_i || (last_grant_q == SRC_IF));
    winner     = win_ls ? SRC_LS : SRC_IF;
    win_acc    = win_ls ? bus.ls_acc_i : `MEM_ACCESS_WORD;
    win_addr   = win_ls ? bus.ls_addr_i : bus.if_addr_i;
    accept     = rstn_i && (state_q == IDLE) && bus.wr_ready_i &&
                 (bus.if_req_i || bus.ls_req_i);
    misaligned = 1'b0;
    case (win_acc)
      `MEM_ACCESS_BYTE:     misaligned = 1'b0;
      `MEM_ACCESS_HALFWORD: misaligned = win_addr[0];
      default:              misaligned = |win_addr[1:0];
    endcase
    rd_last    = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !misaligned)
          state_d = (win_ls && bus.ls_we_i) ? WR_ISSUE : READ;
      end
      READ:     if (rd_last) state_d = IDLE;
      WR_ISSUE: state_d = WR_PEND;
      WR_PEND:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.if_gnt_o    = accept && !win_ls;
    bus.ls_gnt_o    = accept && win_ls;
    bus.r_en_o      = (state_q == READ);
    bus.wr_en_o     = (state_q == WR_ISSUE);
    bus.addr_r_o    = addr_q;
    bus.acc_r_o     = acc_q;
    bus.sext_o      = sext_q;
    bus.addr_w_o    = waddr_q;
    bus.acc_w_o     = wacc_q;
    bus.data_w_o    = wdata_q;
    bus.if_rdata_o  = if_rdata_q;
    bus.ls_rdata_o  = ls_rdata_q;
    bus.if_rvalid_o = if_rvalid_q;
    bus.ls_rvalid_o = ls_rvalid_q;
    bus.ls_wdone_o  = ls_wdone_q;
    bus.if_err_o    = if_err_q;
    bus.ls_err_o    = ls_err_q;
  end

  // Write-port fields load only on a store grant so they hold across later loads.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_grant_q <= SRC_LS;
      src_q        <= SRC_IF;
      sext_q       <= 1'b0;
      acc_q        <= '0;
      addr_q       <= '0;
      wacc_q       <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
      if_rvalid_q  <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      ls_wdone_q   <= 1'b0;
      if_err_q     <= 1'b0;
      ls_err_q     <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_wdone_q  <= 1'b0;
      if_err_q    <= 1'b0;
      ls_err_q    <= 1'b0;

      if (accept) begin
        last_grant_q <= winner;
        src_q        <= winner;
        acc_q        <= win_acc;
        addr_q       <= win_addr;
        sext_q       <= win_ls && bus.ls_sext_i;
        cnt_q        <= '0;
        if (misaligned) begin
          if (win_ls) ls_err_q <= 1'b1;
          else        if_err_q <= 1'b1;
        end else if (win_ls && bus.ls_we_i) begin
          wacc_q  <= bus.ls_acc_i;
          waddr_q <= bus.ls_addr_i;
          wdata_q <= bus.ls_wdata_i;
        end
      end

      if (state_q == READ) begin
        cnt_q <= cnt_q + 1'b1;
        if (rd_last) begin
          if (src_q == SRC_LS) begin
            ls_rdata_q  <= bus.data_r_i;
            ls_rvalid_q <= 1'b1;
          end else begin
            if_rdata_q  <= bus.data_r_i;
            if_rvalid_q <= 1'b1;
          end
        end
      end

      if (state_q == WR_PEND) ls_wdone_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small mem_control model (combinational
// read with byte/half extraction, read-modify-write store committed one cycle after wr_en).
module tb_mem_arbiter;

  localparam logic [1:0] ACC_B = 2'b00;
  localparam logic [1:0] ACC_H = 2'b01;
  localparam logic [1:0] ACC_W = 2'b10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.RD_LAT(1)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- mem_control model ----------------
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;
  logic        pend = 1'b0;
  logic [7:0]  pend_idx;
  logic [31:0] pend_word;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] acc,
                                        input logic [1:0] a, input logic [31:0] d);
    logic [31:0] mask, val;
    case (acc)
      ACC_B: begin
        mask = 32'h0000_00FF << {a, 3'b000};
        val  = {24'h0, d[7:0]} << {a, 3'b000};
      end
      ACC_H: begin
        mask = 32'h0000_FFFF << {a[1], 4'b0000};
        val  = {16'h0, d[15:0]} << {a[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        val  = d;
      end
    endcase
    return (old & ~mask) | (val & mask);
  endfunction

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 8'h80) ? 32'h8001_0000 : (32'hC0DE_0000 | 32'(i));
      mem_init <= 1'b1;
      pend     <= 1'b0;
    end else begin
      pend <= bus.wr_en_o;
      if (bus.wr_en_o) begin
        pend_idx  <= bus.addr_w_o[9:2];
        pend_word <= merge(mem[bus.addr_w_o[9:2]], bus.acc_w_o, bus.addr_w_o[1:0], bus.data_w_o);
      end
      if (pend) mem[pend_idx] <= pend_word;
    end
  end

  logic [31:0] rd_word, rd_sh;
  always_comb begin
    rd_word = mem[bus.addr_r_o[9:2]];
    rd_sh   = rd_word >> {bus.addr_r_o[1:0], 3'b000};
    case (bus.acc_r_o)
      ACC_B:   bus.data_r_i = bus.sext_o ? {{24{rd_sh[7]}}, rd_sh[7:0]}   : {24'h0, rd_sh[7:0]};
      ACC_H:   bus.data_r_i = bus.sext_o ? {{16{rd_sh[15]}}, rd_sh[15:0]} : {16'h0, rd_sh[15:0]};
      default: bus.data_r_i = rd_word;
    endcase
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.ls_req_i   = 1'b0;
    bus.ls_we_i    = 1'b0;
    bus.ls_acc_i   = ACC_W;
    bus.ls_sext_i  = 1'b0;
    bus.ls_addr_i  = '0;
    bus.ls_wdata_i = '0;
  endtask

  task automatic ls_set(input logic we, input logic [1:0] acc, input logic sx,
                        input logic [31:0] addr, input logic [31:0] wd);
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = we;
    bus.ls_acc_i   = acc;
    bus.ls_sext_i  = sx;
    bus.ls_addr_i  = addr;
    bus.ls_wdata_i = wd;
  endtask

  initial begin
    idle_inputs();
    bus.wr_ready_i = 1'b0;
    rstn = 1'b0;
    repeat (3) step();

    // Reset state, request present during reset
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h100;
    settle();
    chk("rst_if_gnt",   bus.if_gnt_o, 0);
    chk("rst_r_en",     bus.r_en_o, 0);
    chk("rst_wr_en",    bus.wr_en_o, 0);
    chk("rst_if_rdata", bus.if_rdata_o, 0);
    chk("rst_ls_rdata", bus.ls_rdata_o, 0);
    chk("rst_addr_w",   bus.addr_w_o, 0);
    chk("rst_if_rvalid", bus.if_rvalid_o, 0);

    // Release reset with wr_ready low: no grant
    rstn = 1'b1;
    settle();
    chk("nordy_gnt", bus.if_gnt_o, 0);
    step(); settle();
    chk("nordy_gnt2", bus.if_gnt_o, 0);
    chk("nordy_r_en", bus.r_en_o, 0);

    // wr_ready high: IF read @0x100, rvalid 2 cycles after gnt
    step();
    bus.wr_ready_i = 1'b1;
    settle();
    chk("if_gnt", bus.if_gnt_o, 1);
    chk("if_gnt_ls", bus.ls_gnt_o, 0);
    step();
    bus.if_req_i = 1'b0;
    settle();
    chk("if_rd_r_en",   bus.r_en_o, 1);
    chk("if_rd_addr",   bus.addr_r_o, 32'h100);
    chk("if_rd_acc",    bus.acc_r_o, ACC_W);
    chk("if_rd_sext",   bus.sext_o, 0);
    chk("if_rvalid_early", bus.if_rvalid_o, 0);
    step(); settle();
    chk("if_rvalid", bus.if_rvalid_o, 1);
    chk("if_rdata",  bus.if_rdata_o, 32'hC0DE_0040);
    chk("if_r_en_off", bus.r_en_o, 0);
    step(); settle();
    chk("if_rvalid_pulse", bus.if_rvalid_o, 0);
    chk("if_rdata_hold",   bus.if_rdata_o, 32'hC0DE_0040);

    // Fresh reset, then both request continuously: IF,LS,IF,LS with no bubble
    rstn = 1'b0;
    settle();
    rstn = 1'b1;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h104;
    ls_set(1'b0, ACC_W, 1'b0, 32'h208, 32'h0);
    settle();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        step(); settle();
      end
      chk($sformatf("alt_if_gnt[%0d]", k), bus.if_gnt_o, 32'((k % 4) == 0));
      chk($sformatf("alt_ls_gnt[%0d]", k), bus.ls_gnt_o, 32'((k % 4) == 2));
      if (k == 2) begin
        chk("alt_if_rvalid", bus.if_rvalid_o, 1);
        chk("alt_if_rdata",  bus.if_rdata_o, 32'hC0DE_0041);
      end
      if (k == 4) begin
        chk("alt_ls_rvalid", bus.ls_rvalid_o, 1);
        chk("alt_ls_rdata",  bus.ls_rdata_o, 32'hC0DE_0082);
      end
    end
    step();
    idle_inputs();
    settle();
    chk("alt_end_ls_rvalid", bus.ls_rvalid_o, 1);
    chk("alt_end_gnt", bus.if_gnt_o | bus.ls_gnt_o, 0);

    // Halfword load @0x202 over 0x80010000: signed, then unsigned back-to-back
    step();
    ls_set(1'b0, ACC_H, 1'b1, 32'h202, 32'h0);
    settle();
    chk("lh_gnt", bus.ls_gnt_o, 1);
    step();
    bus.ls_req_i = 1'b0;
    settle();
    chk("lh_r_en", bus.r_en_o, 1);
    chk("lh_addr", bus.addr_r_o, 32'h202);
    chk("lh_acc",  bus.acc_r_o, ACC_H);
    chk("lh_sext", bus.sext_o, 1);
    step();
    ls_set(1'b0, ACC_H, 1'b0, 32'h202, 32'h0);
    settle();
    chk("lh_rvalid",   bus.ls_rvalid_o, 1);
    chk("lh_rdata_s",  bus.ls_rdata_o, 32'hFFFF_8001);
    chk("lhu_gnt_b2b", bus.ls_gnt_o, 1);
    step();
    bus.ls_req_i = 1'b0;
    settle();
    chk("lhu_sext", bus.sext_o, 0);
    step(); settle();
    chk("lhu_rvalid", bus.ls_rvalid_o, 1);
    chk("lhu_rdata",  bus.ls_rdata_o, 32'h0000_8001);

    // Store byte 0xAB @0x203, then load word @0x200
    step();
    ls_set(1'b1, ACC_B, 1'b0, 32'h203, 32'h1234_56AB);
    settle();
    chk("sb_gnt", bus.ls_gnt_o, 1);
    step();
    bus.ls_req_i = 1'b0;
    settle();
    chk("sb_wr_en",  bus.wr_en_o, 1);
    chk("sb_r_en",   bus.r_en_o, 0);
    chk("sb_addr_w", bus.addr_w_o, 32'h203);
    chk("sb_acc_w",  bus.acc_w_o, ACC_B);
    chk("sb_data_w", bus.data_w_o, 32'h1234_56AB);
    step(); settle();
    chk("sb_pend_wr_en", bus.wr_en_o, 0);
    chk("sb_pend_addr",  bus.addr_w_o, 32'h203);
    chk("sb_pend_wdone", bus.ls_wdone_o, 0);
    step();
    ls_set(1'b0, ACC_W, 1'b0, 32'h200, 32'h0);
    settle();
    chk("sb_wdone",  bus.ls_wdone_o, 1);
    chk("lw_gnt_b2b", bus.ls_gnt_o, 1);
    step();
    bus.ls_req_i = 1'b0;
    settle();
    chk("sb_wdone_pulse", bus.ls_wdone_o, 0);
    chk("lw_r_en", bus.r_en_o, 1);
    step(); settle();
    chk("lw_rvalid", bus.ls_rvalid_o, 1);
    chk("lw_rdata",  bus.ls_rdata_o, 32'hAB01_0000);
    chk("lw_addr_w_hold", bus.addr_w_o, 32'h203);
    chk("lw_data_w_hold", bus.data_w_o, 32'h1234_56AB);

    // Misaligned LS word @0x201 then IF @0x102: gnt, err next cycle, no access
    step();
    ls_set(1'b0, ACC_W, 1'b0, 32'h201, 32'h0);
    settle();
    chk("mis_ls_gnt",  bus.ls_gnt_o, 1);
    chk("mis_ls_r_en", bus.r_en_o, 0);
    step();
    bus.ls_req_i  = 1'b0;
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h102;
    settle();
    chk("mis_ls_err",   bus.ls_err_o, 1);
    chk("mis_if_gnt",   bus.if_gnt_o, 1);
    chk("mis_ls_r_en2", bus.r_en_o, 0);
    chk("mis_ls_wr_en", bus.wr_en_o, 0);
    step();
    bus.if_req_i = 1'b0;
    settle();
    chk("mis_if_err",    bus.if_err_o, 1);
    chk("mis_ls_err_pl", bus.ls_err_o, 0);
    chk("mis_if_r_en",   bus.r_en_o, 0);
    chk("mis_if_wr_en",  bus.wr_en_o, 0);
    step(); settle();
    chk("mis_if_err_pl", bus.if_err_o, 0);
    chk("mis_r_en_end",  bus.r_en_o, 0);
    chk("mis_rvalid",    bus.if_rvalid_o | bus.ls_rvalid_o, 0);

    // Reset during WR_PEND aborts the store: no wdone afterwards
    step();
    ls_set(1'b1, ACC_W, 1'b0, 32'h20C, 32'hDEAD_BEEF);
    settle();
    chk("ab_gnt", bus.ls_gnt_o, 1);
    step();
    bus.ls_req_i = 1'b0;
    settle();
    chk("ab_wr_en", bus.wr_en_o, 1);
    step(); settle();
    chk("ab_pend_data_w", bus.data_w_o, 32'hDEAD_BEEF);
    rstn = 1'b0;
    settle();
    chk("ab_rst_wr_en",   bus.wr_en_o, 0);
    chk("ab_rst_data_w",  bus.data_w_o, 0);
    chk("ab_rst_addr_w",  bus.addr_w_o, 0);
    chk("ab_rst_ls_rdata", bus.ls_rdata_o, 0);
    chk("ab_rst_if_rdata", bus.if_rdata_o, 0);
    chk("ab_rst_wdone",   bus.ls_wdone_o, 0);
    step(); settle();
    chk("ab_rst_wdone2", bus.ls_wdone_o, 0);
    rstn = 1'b1;
    step(); settle();
    chk("ab_post_wdone", bus.ls_wdone_o, 0);
    chk("ab_post_gnt",   bus.ls_gnt_o, 0);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h100;
    settle();
    chk("ab_next_gnt", bus.if_gnt_o, 1);
    step();
    bus.if_req_i = 1'b0;
    settle();
    chk("ab_next_r_en", bus.r_en_o, 1);
    step(); settle();
    chk("ab_next_rvalid", bus.if_rvalid_o, 1);
    chk("ab_next_rdata",  bus.if_rdata_o, 32'hC0DE_0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
